// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix multiplier.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Accumulator width that holds k products of two d-bit operands.
  function automatic int acc_width(input int d, input int k);
    return 2 * d + $clog2(k);
  endfunction

  // Zero-injection cycles for the last operand pair to reach PE(n-1,n-1).
  function automatic int flush_cycles(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One output-stationary processing element: forwards a east and b south,
// and accumulates a*b in place.
module systolic_pe #(
  parameter int DATA_SIZE = 8,
  parameter int ACC_SIZE  = 20,
  parameter bit SIGNED    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  output logic [DATA_SIZE-1:0] a_out,
  output logic [DATA_SIZE-1:0] b_out,
  output logic [ACC_SIZE-1:0]  acc
);

  localparam int PW = 2 * DATA_SIZE;

  logic [PW-1:0]       a_ext;
  logic [PW-1:0]       b_ext;
  logic [PW-1:0]       prod;
  logic [ACC_SIZE-1:0] prod_ext;

  // Operands are extended to product width first; the low PW bits of the
  // product are then exact for both signed and unsigned operands.
  assign a_ext    = {{DATA_SIZE{SIGNED & a_in[DATA_SIZE-1]}}, a_in};
  assign b_ext    = {{DATA_SIZE{SIGNED & b_in[DATA_SIZE-1]}}, b_in};
  assign prod     = a_ext * b_ext;
  assign prod_ext = {{(ACC_SIZE-PW){SIGNED & prod[PW-1]}}, prod};

  // Operand forwarding registers and the wrapping accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      // NOTE: non-blocking so every PE samples its neighbours' pre-edge values.
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_matmul_engine.sv
// N x N output-stationary systolic multiplier C = A*B with input skew,
// start/busy/done control and a row-serial valid/ready result drain.
module systolic_matmul_engine
  import systolic_pkg::*;
#(
  parameter int MATRIX_SIZE = 3,
  parameter int DATA_SIZE   = 8,
  parameter int K_MAX       = 16,
  parameter int KW          = $clog2(K_MAX + 1),
  parameter int ACC_SIZE    = acc_width(DATA_SIZE, K_MAX),
  parameter bit SIGNED      = 1'b1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     start,
  input  logic [KW-1:0]                            k_len,
  output logic                                     busy,
  output logic                                     done,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]    in_a,
  input  logic [MATRIX_SIZE-1:0][DATA_SIZE-1:0]    in_b,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [$clog2(MATRIX_SIZE)-1:0]           out_row_idx,
  output logic [MATRIX_SIZE-1:0][ACC_SIZE-1:0]     out_row
);

  localparam int N       = MATRIX_SIZE;
  localparam int RW      = $clog2(N);
  localparam int FLUSH_N = flush_cycles(N);
  localparam int FW      = $clog2(FLUSH_N + 1);

  state_t state, next_state;

  logic [KW-1:0] k_cap;
  logic [KW-1:0] k_reg;
  logic [KW-1:0] xfer_cnt;
  logic [FW-1:0] flush_cnt;
  logic [RW-1:0] row_idx;

  logic clr;
  logic transfer;
  logic last_xfer;
  logic last_flush;
  logic last_row;

  logic [N-1:0][DATA_SIZE-1:0] inj_a;
  logic [N-1:0][DATA_SIZE-1:0] inj_b;

  // a_h[i][j] feeds PE(i,j) from the west; b_v[i][j] feeds PE(i,j) from the north.
  logic [DATA_SIZE-1:0] a_h   [N][N+1];
  logic [DATA_SIZE-1:0] b_v   [N+1][N];
  logic [ACC_SIZE-1:0]  acc_q [N][N];
  logic                 unused_edge;

  assign k_cap      = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign clr        = (state == ST_IDLE) && start;
  assign transfer   = (state == ST_LOAD) && in_valid;
  assign last_xfer  = (xfer_cnt == k_reg - KW'(1));
  assign last_flush = (flush_cnt == FW'(FLUSH_N - 1));
  assign last_row   = (row_idx == RW'(N - 1));

  // Bubbles inject zeros so idle LOAD cycles add nothing to any accumulator.
  assign inj_a = transfer ? in_a : '0;
  assign inj_b = transfer ? in_b : '0;

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_DONE);
  assign in_ready    = (state == ST_LOAD);
  assign out_valid   = (state == ST_DRAIN);
  assign out_row_idx = row_idx;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves next_state unassigned (no latch).
    next_state = state;
    unique case (state)
      ST_IDLE:  if (start) next_state = (k_cap == '0) ? ST_FLUSH : ST_LOAD;
      ST_LOAD:  if (in_valid && last_xfer) next_state = ST_FLUSH;
      ST_FLUSH: if (last_flush) next_state = ST_DRAIN;
      ST_DRAIN: if (out_ready && last_row) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Job length capture and the transfer, flush and drain-row counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg     <= '0;
      xfer_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
    end else if (clr) begin
      k_reg     <= k_cap;
      xfer_cnt  <= '0;
      flush_cnt <= '0;
      row_idx   <= '0;
    end else begin
      if (transfer) xfer_cnt <= xfer_cnt + KW'(1);
      if (state == ST_FLUSH) flush_cnt <= flush_cnt + FW'(1);
      if ((state == ST_DRAIN) && out_ready) row_idx <= last_row ? '0 : row_idx + RW'(1);
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    logic [i:0][DATA_SIZE-1:0] a_sr;
    logic [i:0][DATA_SIZE-1:0] b_sr;

    // Skew line: row i of A and column i of B enter the array i cycles late.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        // NOTE: skew stages are reset, not left as bare storage, so stale
        // operands can never leak into the next job's products.
        a_sr <= '0;
        b_sr <= '0;
      end else if (clr) begin
        a_sr <= '0;
        b_sr <= '0;
      end else begin
        a_sr[0] <= inj_a[i];
        b_sr[0] <= inj_b[i];
        for (int s = 1; s <= i; s++) begin
          a_sr[s] <= a_sr[s-1];
          b_sr[s] <= b_sr[s-1];
        end
      end
    end

    assign a_h[i][0] = a_sr[i];
    assign b_v[0][i] = b_sr[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(
        .DATA_SIZE (DATA_SIZE),
        .ACC_SIZE  (ACC_SIZE),
        .SIGNED    (SIGNED)
      ) u_pe (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .a_in    (a_h[i][j]),
        .b_in    (b_v[i][j]),
        .a_out   (a_h[i][j+1]),
        .b_out   (b_v[i+1][j]),
        .acc     (acc_q[i][j])
      );
    end
  end

  // Operands leaving the east and south edges of the array are discarded.
  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++) unused_edge = unused_edge ^ (^a_h[i][N]) ^ (^b_v[N][i]);
  end

  // Result row mux; zero outside DRAIN.
  always_comb begin
    out_row = '0;
    if (state == ST_DRAIN) begin
      for (int r = 0; r < N; r++) begin
        if (row_idx == RW'(r)) begin
          for (int j = 0; j < N; j++) out_row[j] = acc_q[r][j];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed, table-driven bench for systolic_matmul_engine (N=3, 8-bit signed).
module tb_systolic_matmul_engine;

  localparam int N    = 3;
  localparam int D    = 8;
  localparam int KMAX = 16;
  localparam int KW   = 5;
  localparam int ACC  = 20;
  localparam int RW   = 2;
  localparam int NV   = 8;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic                     start;
  logic [KW-1:0]            k_len;
  logic                     busy, done;
  logic                     in_valid, in_ready;
  logic [N-1:0][D-1:0]      in_a, in_b;
  logic                     out_valid, out_ready;
  logic [RW-1:0]            out_row_idx;
  logic [N-1:0][ACC-1:0]    out_row;

  always #5 clk = ~clk;

  systolic_matmul_engine #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (D),
    .K_MAX       (KMAX),
    .KW          (KW),
    .ACC_SIZE    (ACC),
    .SIGNED      (1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .k_len       (k_len),
    .busy        (busy),
    .done        (done),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_row_idx (out_row_idx),
    .out_row     (out_row)
  );

  // a_kind: 0 = identity, 1 = constant a_val.  b_kind: 0 = B[k][j]=3k+j+1, 1 = constant b_val.
  typedef struct packed {
    int             k;
    int             a_kind;
    int             a_val;
    int             b_kind;
    int             b_val;
    logic [7:0]     vpat;
    int             stall;
    int             exp_first;
    int             exp_done;
    logic [8:0][31:0] exp_c;
  } vec_t;

  vec_t tv [NV];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [N-1:0][ACC-1:0] got [N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_all(input int v, input int val);
    for (int n = 0; n < 9; n++) tv[v].exp_c[n] = val;
  endtask

  task automatic run_vec(input int v);
    vec_t t;
    logic [N-1:0][D-1:0] av [KMAX];
    logic [N-1:0][D-1:0] bv [KMAX];
    logic [N-1:0][ACC-1:0] held;
    logic [N-1:0][ACC-1:0] exp_row;
    int xi, lc, first, done_at, stall, accepted;
    logic prev_xfer, ready_seen;
    t = tv[v];
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < N; i++) begin
        av[k][i] = (t.a_kind == 0) ? ((i == k) ? D'(1) : D'(0)) : D'(t.a_val);
        bv[k][i] = (t.b_kind == 0) ? D'(3 * k + i + 1) : D'(t.b_val);
      end
    end
    for (int r = 0; r < N; r++) got[r] = '0;
    held = '0;
    xi = 0; lc = 0; first = -1; done_at = -1; stall = t.stall; accepted = 0;
    prev_xfer = 1'b0; ready_seen = 1'b0;

    @(negedge clk);
    start = 1'b1; k_len = KW'(t.k); in_valid = 1'b0; out_ready = 1'b1;
    in_a = av[0]; in_b = bv[0];

    // Cycle e is the e-th cycle after the one presenting start.
    for (int e = 1; e <= 300 && done_at < 0; e++) begin
      @(negedge clk);
      start = 1'b0;
      if (prev_xfer) xi++;
      if (in_ready) ready_seen = 1'b1;
      if (e == 1) check($sformatf("v%0d_busy_c1", v), busy, 1);
      if (done) done_at = e;
      out_ready = 1'b1;
      if (out_valid) begin
        if (first < 0) begin
          first = e;
          held  = out_row;
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
          check($sformatf("v%0d_stall_hold", v), {out_row_idx, out_row}, {2'b00, held});
        end else begin
          check($sformatf("v%0d_row_order", v), out_row_idx, accepted);
          if (accepted < N) got[accepted] = out_row;
          accepted++;
        end
      end
      if (in_ready) begin
        in_valid = t.vpat[lc % 8];
        lc++;
      end else begin
        in_valid = 1'b0;
      end
      in_a = av[(xi < KMAX) ? xi : KMAX - 1];
      in_b = bv[(xi < KMAX) ? xi : KMAX - 1];
      prev_xfer = in_valid && in_ready;
    end

    check($sformatf("v%0d_first_valid", v), first, t.exp_first);
    check($sformatf("v%0d_done_cycle", v), done_at, t.exp_done);
    check($sformatf("v%0d_in_ready_seen", v), ready_seen, (t.k > 0));
    for (int r = 0; r < N; r++) begin
      for (int j = 0; j < N; j++) exp_row[j] = ACC'(t.exp_c[r * 3 + j]);
      check($sformatf("v%0d_row%0d", v, r), got[r], exp_row);
    end
    @(negedge clk);
    check($sformatf("v%0d_after_done", v), {busy, done}, 2'b00);
  endtask

  initial begin
    for (int v = 0; v < NV; v++) begin
      tv[v] = '0;
      tv[v].vpat = 8'hFF;
      tv[v].a_kind = 1;
      tv[v].b_kind = 1;
    end
    // Identity times B -> B.
    tv[0].k = 3; tv[0].a_kind = 0; tv[0].b_kind = 0; tv[0].exp_first = 9; tv[0].exp_done = 12;
    for (int n = 0; n < 9; n++) tv[0].exp_c[n] = n + 1;
    // Empty inner dimension: all zero, no LOAD.
    tv[1].k = 0; tv[1].a_val = 5; tv[1].b_val = 7; tv[1].exp_first = 6; tv[1].exp_done = 9;
    set_all(1, 0);
    // 16 * (-128 * -128) = 262144.
    tv[2].k = 16; tv[2].a_val = -128; tv[2].b_val = -128; tv[2].exp_first = 22; tv[2].exp_done = 25;
    set_all(2, 262144);
    // Bubbled LOAD 1,0,0,1,1: 3 * 2 * 2 = 12.
    tv[3].k = 3; tv[3].a_val = 2; tv[3].b_val = 2; tv[3].vpat = 8'h19;
    tv[3].exp_first = 11; tv[3].exp_done = 14;
    set_all(3, 12);
    // Downstream stalls 5 cycles on row 0.
    tv[4].k = 3; tv[4].a_kind = 0; tv[4].b_kind = 0; tv[4].stall = 5;
    tv[4].exp_first = 9; tv[4].exp_done = 17;
    for (int n = 0; n < 9; n++) tv[4].exp_c[n] = n + 1;
    // k_len 20 clamps to 16: 16 * 1 * 1.
    tv[5].k = 20; tv[5].a_val = 1; tv[5].b_val = 1; tv[5].exp_first = 22; tv[5].exp_done = 25;
    set_all(5, 16);
    // Mixed sign: 2 * 3 * -5 = -30.
    tv[6].k = 2; tv[6].a_val = 3; tv[6].b_val = -5; tv[6].exp_first = 8; tv[6].exp_done = 11;
    set_all(6, -30);
    // Job following an aborted run: 1 * 1 * 2 = 2.
    tv[7].k = 1; tv[7].a_val = 1; tv[7].b_val = 2; tv[7].exp_first = 7; tv[7].exp_done = 10;
    set_all(7, 2);

    reset_n = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, in_ready, out_valid, out_row_idx, out_row}, '0);
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) run_vec(v);

    // Abort a job during FLUSH with reset.
    @(negedge clk);
    start = 1'b1; k_len = KW'(3); in_valid = 1'b1; out_ready = 1'b1;
    in_a = {N{8'sd1}}; in_b = {N{8'sd1}};
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_flush", {busy, in_ready, out_valid}, 3'b100);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_zero", {busy, done, in_ready, out_valid, out_row_idx, out_row}, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_%0d", c), {done, busy}, 2'b00);
    end
    reset_n = 1'b1;
    in_valid = 1'b0;
    run_vec(7);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_engine.md
Name: systolic_matmul_engine

Overview:
- Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B, with A of size N×K and B of size K×N. K is set at runtime up to K_MAX.
- Contains its own input skew registers, widened accumulators, a start/busy/done control FSM, and a row-serial result drain with a valid/ready handshake.
- Sits between the operand buffers and the classifier datapath.

Parameters:
- MATRIX_SIZE, 3, array dimension N (≥2).
- DATA_SIZE, 8, operand width.
- K_MAX, 16, maximum inner dimension.
- KW, $clog2(K_MAX+1), width of k_len.
- ACC_SIZE, 2*DATA_SIZE+$clog2(K_MAX), accumulator/result width.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k_len  in  KW  inner dimension, captured with start; values >K_MAX clamp to K_MAX.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the last result row is accepted.
- in_valid  in  1  operand vector pair valid.
- in_ready  out  1  high in LOAD only.
- in_a  in  [DATA_SIZE-1:0] x MATRIX_SIZE  column k of A; element i is A[i][k].
- in_b  in  [DATA_SIZE-1:0] x MATRIX_SIZE  row k of B; element j is B[k][j].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the row.
- out_row_idx  out  $clog2(MATRIX_SIZE)  row index r of the current output.
- out_row  out  [ACC_SIZE-1:0] x MATRIX_SIZE  C[r][0..N-1].

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE. busy, done, in_ready, out_valid, out_row_idx, out_row, all skew registers, PE pipe registers and accumulators are 0.
- FSM states are IDLE, LOAD, FLUSH, DRAIN, DONE.
- IDLE:
  - start=1 clears all accumulators and skew registers and captures k_len.
  - Next state is LOAD, or FLUSH if k_len==0.
  - start in any other state is ignored.
- LOAD:
  - A transfer occurs on in_valid&&in_ready.
  - Each transfer injects in_a/in_b into the skew stage. Row i of A is delayed i cycles; column j of B is delayed j cycles.
  - A cycle without a transfer injects zeros, so bubbles do not change any result.
  - After k_len transfers the FSM moves to FLUSH. in_ready drops in the same cycle as the last transfer registers.
- PE(i,j):
  - Passes a east and b south, each through one register.
  - Computes acc <= acc + a*b. The product is sign- or zero-extended per SIGNED to ACC_SIZE; the add wraps modulo 2^ACC_SIZE.
- FLUSH:
  - Zeros are injected for exactly 2*MATRIX_SIZE-1 cycles, which is enough for the last product to reach PE(N-1,N-1) and accumulate.
  - Then the FSM moves to DRAIN.
- DRAIN:
  - out_valid=1 and out_row_idx=r, starting at r=0; out_row shows acc[r][*].
  - Row r holds stable until out_valid&&out_ready, then r increments.
  - Acceptance of row N-1 moves the FSM to DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, then IDLE.
- Latency with in_valid held high and out_ready held high: start accepted at cycle 0; first out_valid at cycle 1+k_len+2N-1; done one cycle after the last row is accepted.
- k_len==0: all result rows are 0.
- Reset mid-operation aborts with no done pulse. Accumulators are zeroed.

Decomposition:
- Package systolic_pkg:
  - typedef of the FSM state enum.
  - function acc_width(d,k).
  - localparam FLUSH_CYCLES(n) = 2n-1.
- Sub-module systolic_pe: one PE with parameters DATA_SIZE, ACC_SIZE, SIGNED.
  - Ports: clk, reset_n, clr, a_in, b_in, a_out, b_out, acc.
  - Generated N×N times.
- The skew lines are generate loops of shift registers in the top level.

Test Plan:
- N=3, k_len=3, A=identity, B=[[1,2,3],[4,5,6],[7,8,9]], in_valid and out_ready held high → rows 0..2 = B; first out_valid at cycle 9; done at cycle 12.
- k_len=0 → three all-zero rows; no in_ready.
- SIGNED=1, k_len=16, all operands -128 → every element = 262144. No wrap with ACC_SIZE=20.
- LOAD with in_valid toggling 1,0,0,1,1 (k_len=3, A=B=all-2) → every element = 12; bubbles have no effect.
- out_ready low for 5 cycles during DRAIN → row 0 and out_row_idx hold stable; rows then appear in order 0,1,2.
- reset_n asserted during FLUSH → all outputs 0 immediately, no done pulse. A following start with k_len=1, in_a=[1,1,1], in_b=[2,2,2] → every element = 2.
